pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Consumes the lock indication of the board PLL and produces the synchronous core reset for the J1 clock domain driven by that PLL output. Qualifies lock over a stable window, holds reset for a fixed count after qualification, and re-asserts reset immediately on loss of lock. Exports a saturating lock-loss counter and the state encoding for debug and UART status reporting.

Parameters:
SYNC_STAGES, 2, synchronizer flops on isLocked (legal values 2..4).
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before leaving LOCK_QUALIFY (>=1).
RESET_HOLD_CYCLES, 16, cycles coreReset remains high after qualification (>=1).
CNT_WIDTH, 16, width of the shared cycle counter; must hold max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES).
LOSS_WIDTH, 8, width of the lock-loss counter.

Ports:
clk  input  1  PLL output clock, the only clock
reset  input  1  synchronous active-high reset (board/button reset already in clk domain)
isLocked  input  1  raw PLL lock, asynchronous to clk
coreReset  output  1  synchronous active-high reset for downstream core logic
isReady  output  1  high only in RUN
lockLossCount  output  LOSS_WIDTH  number of RUN->lock-lost events, saturating
state  output  2  current FSM state encoding

Behaviour:
- Single clock domain (clk); reset synchronous, active-high. All outputs registered.
- isLocked goes through SYNC_STAGES flops (reset to 0); lockSync = last stage. All FSM decisions use lockSync only.
- While reset=1 (sampled at clk edge): state=WAIT_LOCK (2'b00), coreReset=1, isReady=0, counter=0, lockLossCount=0, synchronizer cleared.
- States: WAIT_LOCK=00, LOCK_QUALIFY=01, HOLD=10, RUN=11.
- WAIT_LOCK: coreReset=1, counter=0. lockSync=1 -> LOCK_QUALIFY with counter=1.
- LOCK_QUALIFY: coreReset=1. lockSync=0 -> WAIT_LOCK, counter=0 (no loss count). lockSync=1 and counter==LOCK_STABLE_CYCLES -> HOLD, counter=1; else counter+1.
- HOLD: coreReset=1. lockSync=0 -> WAIT_LOCK (no loss count). counter==RESET_HOLD_CYCLES -> RUN, counter=0; else counter+1.
- RUN: coreReset=0, isReady=1. lockSync=0 -> WAIT_LOCK; coreReset and isReady change on the same edge as the transition (outputs reflect new state next cycle, i.e. reset reasserted 1 cycle after lockSync falls); lockLossCount+1 unless all-ones (saturate, no wrap).
- Latency, lock rising at isLocked to coreReset falling: SYNC_STAGES + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES + 1 cycles (+/-1 for async sampling).
- Glitch on isLocked shorter than one clk period may or may not be captured; any captured low during QUALIFY/HOLD restarts qualification.
- reset asserted mid-RUN: coreReset=1 next edge; lockLossCount cleared (reset is not a lock loss).
- reset and lockSync fall on the same edge: reset wins; counter not incremented.
- Counter never wraps: it is bounded by the transitions above; CNT_WIDTH check via elaboration-time assertion.
- coreReset must never be 0 outside RUN; isReady == ~coreReset at all times.

Test Plan:
- Power-up: reset=1 for 5 cycles, isLocked=0 -> coreReset=1, isReady=0, state=00, lockLossCount=0 throughout.
- Clean lock (defaults): reset released, isLocked=1 at cycle 10 -> coreReset falls exactly 2+1024+16+1 cycles later (±1), state sequence 00->01->10->11.
- Lock chatter: isLocked low for 3 cycles at cycle 500 of QUALIFY -> state back to 00, qualification restarts from 1, lockLossCount stays 0, coreReset never drops.
- Loss in RUN: after RUN, isLocked=0 -> coreReset=1 within SYNC_STAGES+1 cycles, lockLossCount=1, state=00; re-lock returns to RUN after full sequence.
- Saturation: LOSS_WIDTH=2, force 5 RUN->loss cycles -> lockLossCount reads 1,2,3,3,3.
- Reset mid-HOLD and mid-RUN: reset pulse 1 cycle -> state=00, counter=0, lockLossCount=0, coreReset=1 next cycle; with isLocked held high, full sequence repeats.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Turns the raw PLL lock into a qualified, held core reset for the J1 clock domain.
// Also keeps a saturating count of lock losses seen while running.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int CNT_WIDTH          = 16,
    parameter int LOSS_WIDTH         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  isLocked,
    output logic                  coreReset,
    output logic                  isReady,
    output logic [LOSS_WIDTH-1:0] lockLossCount,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        WAIT_LOCK    = 2'b00,
        LOCK_QUALIFY = 2'b01,
        HOLD         = 2'b10,
        RUN          = 2'b11
    } seqState_t;

    localparam int MAX_COUNT = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;

    // Reject parameter sets the counter or synchronizer cannot support.
    generate
        if (CNT_WIDTH < 32 && MAX_COUNT >= (1 << CNT_WIDTH)) begin : gBadCntWidth
            $error("pll_reset_sequencer: CNT_WIDTH too small for cycle counts");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gBadSyncStages
            $error("pll_reset_sequencer: SYNC_STAGES must be 2..4");
        end
        if (LOCK_STABLE_CYCLES < 1 || RESET_HOLD_CYCLES < 1) begin : gBadCycles
            $error("pll_reset_sequencer: cycle counts must be at least 1");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(RESET_HOLD_CYCLES);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   lockSync;
    seqState_t              currentState;
    logic [CNT_WIDTH-1:0]   counter;

    assign lockSync = syncChain[SYNC_STAGES-1];
    assign state    = currentState;

    always_ff @(posedge clk) begin
        if (reset) begin
            syncChain <= '0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], isLocked};
        end
    end

    // Any captured low outside RUN silently restarts qualification; only RUN losses count.
    always_ff @(posedge clk) begin
        if (reset) begin
            currentState  <= WAIT_LOCK;
            counter       <= '0;
            coreReset     <= 1'b1;
            isReady       <= 1'b0;
            lockLossCount <= '0;
        end else begin
            coreReset <= 1'b1;
            isReady   <= 1'b0;
            case (currentState)
                WAIT_LOCK: begin
                    if (lockSync) begin
                        currentState <= LOCK_QUALIFY;
                        counter      <= CNT_WIDTH'(1);
                    end else begin
                        counter <= '0;
                    end
                end
                LOCK_QUALIFY: begin
                    if (!lockSync) begin
                        currentState <= WAIT_LOCK;
                        counter      <= '0;
                    end else if (counter == STABLE_LAST) begin
                        currentState <= HOLD;
                        counter      <= CNT_WIDTH'(1);
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                HOLD: begin
                    if (!lockSync) begin
                        currentState <= WAIT_LOCK;
                        counter      <= '0;
                    end else if (counter == HOLD_LAST) begin
                        currentState <= RUN;
                        counter      <= '0;
                        coreReset    <= 1'b0;
                        isReady      <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                RUN: begin
                    if (!lockSync) begin
                        currentState <= WAIT_LOCK;
                        counter      <= '0;
                        if (lockLossCount != '1) begin
                            lockLossCount <= lockLossCount + 1'b1;
                        end
                    end else begin
                        coreReset <= 1'b0;
                        isReady   <= 1'b1;
                    end
                end
                default: begin
                    currentState <= WAIT_LOCK;
                    counter      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock activity,
// checked every cycle against a lock-streak model of the sequencer.
module tb_pll_reset_sequencer;

    localparam int SYNC  = 2;
    localparam int LSTAB = 1024;
    localparam int HOLDC = 16;
    localparam int LOSSW = 2;
    localparam int LOSS_MAX = (1 << LOSSW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             isLocked;
    logic             coreReset;
    logic             isReady;
    logic [LOSSW-1:0] lockLossCount;
    logic [1:0]       state;

    int vectors;
    int miscompares;

    bit syncModel[SYNC];
    int streakModel;
    int lossModel;

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC),
        .LOCK_STABLE_CYCLES(LSTAB),
        .RESET_HOLD_CYCLES(HOLDC),
        .CNT_WIDTH(16),
        .LOSS_WIDTH(LOSSW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .isLocked(isLocked),
        .coreReset(coreReset),
        .isReady(isReady),
        .lockLossCount(lockLossCount),
        .state(state)
    );

    always #5 clk = ~clk;

    // The sequencer's position is fully determined by how many consecutive
    // synchronized-locked edges have been seen since the last low or reset.
    function automatic logic [1:0] expState(input int s);
        if (s == 0)                 return 2'd0;
        else if (s <= LSTAB)        return 2'd1;
        else if (s <= LSTAB + HOLDC) return 2'd2;
        else                        return 2'd3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic modelEdge(input logic r, input logic lk);
        bit seen;
        if (r) begin
            for (int i = 0; i < SYNC; i++) syncModel[i] = 1'b0;
            streakModel = 0;
            lossModel   = 0;
        end else begin
            seen = syncModel[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) syncModel[i] = syncModel[i-1];
            syncModel[0] = lk;
            if (seen) begin
                if (streakModel <= LSTAB + HOLDC) streakModel++;
            end else begin
                if (streakModel > LSTAB + HOLDC && lossModel < LOSS_MAX) lossModel++;
                streakModel = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic lk);
        logic [1:0] es;
        reset    = r;
        isLocked = lk;
        @(posedge clk);
        modelEdge(r, lk);
        #1;
        es = expState(streakModel);
        checkOutput("state", state, es);
        checkOutput("coreReset", coreReset, (es != 2'd3));
        checkOutput("isReady", isReady, (es == 2'd3));
        checkOutput("lockLossCount", lockLossCount, lossModel);
    endtask

    task automatic waitReady(input string tag);
        int guard;
        guard = 0;
        while (!isReady && guard < 2000) begin
            applyStimulus(1'b0, 1'b1);
            guard++;
        end
        checkOutput(tag, isReady, 1);
    endtask

    logic [1:0] satTable[5];
    int latency;
    int guard;
    int dur;
    logic lk;
    logic r;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        isLocked    = 1'b0;
        for (int i = 0; i < SYNC; i++) syncModel[i] = 1'b0;
        streakModel = 0;
        lossModel   = 0;
        satTable = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Power-up reset, then idle unlocked until cycle 10.
        repeat (5) applyStimulus(1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);

        // Clean lock: count cycles from lock rising until isReady.
        latency = 0;
        while (!isReady && latency < 2000) begin
            applyStimulus(1'b0, 1'b1);
            latency++;
        end
        checkOutput("lockLatency", latency, SYNC + LSTAB + HOLDC + 1);
        repeat (20) applyStimulus(1'b0, 1'b1);

        // Five losses from RUN; first relock includes chatter mid-qualification.
        for (int k = 0; k < 5; k++) begin
            repeat (SYNC + 2) applyStimulus(1'b0, 1'b0);
            checkOutput("lossSaturation", lockLossCount, satTable[k]);
            if (k == 0) begin
                repeat (500) applyStimulus(1'b0, 1'b1);
                repeat (3) applyStimulus(1'b0, 1'b0);
                checkOutput("chatterRestart", state, 2'd0);
                checkOutput("chatterLossCount", lockLossCount, 1);
            end
            waitReady("relockReady");
            repeat (5) applyStimulus(1'b0, 1'b1);
        end

        // Reset pulse mid-HOLD, then let the full sequence repeat.
        repeat (SYNC + 2) applyStimulus(1'b0, 1'b0);
        guard = 0;
        while (streakModel != LSTAB + 5 && guard < 3000) begin
            applyStimulus(1'b0, 1'b1);
            guard++;
        end
        checkOutput("reachedHold", state, 2'd2);
        applyStimulus(1'b1, 1'b1);
        checkOutput("resetHoldState", state, 2'd0);
        waitReady("readyAfterHoldReset");

        // Reset pulse mid-RUN clears the loss count and restarts the sequence.
        repeat (SYNC + 2) applyStimulus(1'b0, 1'b0);
        waitReady("readyBeforeRunReset");
        checkOutput("lossBeforeRunReset", lockLossCount, 1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("resetRunCoreReset", coreReset, 1);
        checkOutput("resetRunLoss", lockLossCount, 0);
        waitReady("readyAfterRunReset");

        // Reset lands on the same edge the synchronized lock falls.
        repeat (SYNC) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("resetWinsLoss", lockLossCount, 0);

        // Random lock activity with occasional single-cycle resets.
        for (int seg = 0; seg < 60; seg++) begin
            dur = $urandom_range(1, 80);
            lk  = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 19) == 0);
            applyStimulus(r, lk);
            repeat (dur - 1) applyStimulus(1'b0, lk);
        end
        waitReady("finalReady");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
